// File: rtl/pg_pkg.sv
// Shared types, default parameter values and the round-robin helper
// used by the IO power sequencer.
package pg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SD_CLK = 3'd1,
        ST_SD_ISO = 3'd2,
        ST_SD_PWR = 3'd3,
        ST_WK_PWR = 3'd4,
        ST_WK_ISO = 3'd5
    } pg_state_e;

    localparam int DEF_N_DOM          = 4;
    localparam int DEF_IDLE_THRESHOLD = 5;
    localparam int DEF_CLK_SETTLE     = 2;
    localparam int DEF_ISO_SETTLE     = 2;
    localparam int DEF_PWR_RAMP       = 4;

    // Widest request vector the arbiter helper handles (N_DOM <= 8).
    localparam int RR_MAX = 8;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping inside the lowest n bits.
    function automatic rr_pick_t rr_find_first(input logic [RR_MAX-1:0] req,
                                               input int ptr,
                                               input int n);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                cand = (ptr + k) % n;
                if (!res.hit && req[3'(cand)]) begin
                    res.hit = 1'b1;
                    res.idx = 3'(cand);
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pg_idle_timer.sv
// Per-domain saturating idle counter; flags the domain as a shutdown
// candidate once it has been quiet for the threshold number of cycles.
module pg_idle_timer
    import pg_pkg::*;
#(
    parameter int IDLE_THRESHOLD = DEF_IDLE_THRESHOLD
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_activity,
    input  logic i_force_on,
    input  logic i_clear,
    output logic o_eligible
);

    logic [3:0] r_count;
    logic       w_sat;

    assign w_sat      = (r_count == 4'(IDLE_THRESHOLD));
    assign o_eligible = i_en & w_sat & ~i_force_on & ~i_activity;

    // Count consecutive quiet cycles while the domain is on; hold while off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 4'd0;
        end else if (i_clear) begin
            r_count <= 4'd0;
        end else if (!i_en) begin
            r_count <= r_count;
        end else if (i_activity) begin
            r_count <= 4'd0;
        end else if (!w_sat) begin
            r_count <= r_count + 4'd1;
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/pg_invariant_chk.sv
// Safety invariants on the per-domain clock/isolation/power controls.
module pg_invariant_chk #(
    parameter int N_DOM = 4
) (
    input logic             clk,
    input logic             reset,
    input logic [N_DOM-1:0] clk_en,
    input logic [N_DOM-1:0] iso_en,
    input logic [N_DOM-1:0] pwr_en
);

    logic [N_DOM-1:0] w_mid;

    // A domain is mid-transition when it is neither fully on nor fully off.
    assign w_mid = ~(clk_en & ~iso_en & pwr_en) & ~(~clk_en & iso_en & ~pwr_en);

    for (genvar g = 0; g < N_DOM; g++) begin : g_dom
        a_clk_safe: assert property (@(posedge clk) disable iff (reset)
            clk_en[g] |-> (!iso_en[g] && pwr_en[g]));
        a_iso_safe: assert property (@(posedge clk) disable iff (reset)
            !iso_en[g] |-> pwr_en[g]);
    end

    a_one_mid: assert property (@(posedge clk) disable iff (reset) $onehot0(w_mid));

endmodule

// File: rtl/io_power_sequencer.sv
// Central power sequencer: arbitrates one transition at a time among the
// gated IO domains and steps clock gate, isolation and power switch with
// settle delays between them.
module io_power_sequencer
    import pg_pkg::*;
#(
    parameter int N_DOM          = DEF_N_DOM,
    parameter int IDLE_THRESHOLD = DEF_IDLE_THRESHOLD,
    parameter int CLK_SETTLE     = DEF_CLK_SETTLE,
    parameter int ISO_SETTLE     = DEF_ISO_SETTLE,
    parameter int PWR_RAMP       = DEF_PWR_RAMP,
    localparam int DW            = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_DOM-1:0] activity,
    input  logic [N_DOM-1:0] wake_req,
    input  logic [N_DOM-1:0] force_on,
    output logic [N_DOM-1:0] clk_en,
    output logic [N_DOM-1:0] iso_en,
    output logic [N_DOM-1:0] pwr_en,
    output logic [N_DOM-1:0] dom_ready,
    output logic             busy,
    output logic [DW-1:0]    cur_dom
);

    pg_state_e        r_state, w_state_nxt;
    logic [3:0]       r_wait, w_wait_nxt;
    logic [N_DOM-1:0] r_clk_en, w_clk_en_nxt;
    logic [N_DOM-1:0] r_iso_en, w_iso_en_nxt;
    logic [N_DOM-1:0] r_pwr_en, w_pwr_en_nxt;
    logic [N_DOM-1:0] r_rdy, w_rdy_nxt;
    logic [N_DOM-1:0] r_dom_on, w_dom_on_nxt;
    logic             r_busy, w_busy_nxt;
    logic [DW-1:0]    r_cur_dom, w_cur_nxt;
    logic [DW-1:0]    r_rr_ptr, w_rr_nxt;

    logic [N_DOM-1:0]  w_sd_elig, w_wk_elig, w_clear;
    logic [RR_MAX-1:0] w_sd_req, w_wk_req;
    rr_pick_t          w_sd_pick, w_wk_pick;
    logic [DW-1:0]     w_grant, w_rr_inc;
    logic              w_abort;

    for (genvar g = 0; g < N_DOM; g++) begin : g_timer
        pg_idle_timer #(.IDLE_THRESHOLD(IDLE_THRESHOLD)) u_timer (
            .clk        (clk),
            .reset      (reset),
            .i_en       (r_dom_on[g]),
            .i_activity (activity[g]),
            .i_force_on (force_on[g]),
            .i_clear    (w_clear[g]),
            .o_eligible (w_sd_elig[g])
        );
    end

    pg_invariant_chk #(.N_DOM(N_DOM)) u_chk (
        .clk    (clk),
        .reset  (reset),
        .clk_en (r_clk_en),
        .iso_en (r_iso_en),
        .pwr_en (r_pwr_en)
    );

    // Wake always wins over shutdown; round-robin order within each class.
    assign w_wk_elig = ~r_dom_on & (wake_req | force_on | activity);
    assign w_wk_req  = RR_MAX'(w_wk_elig);
    assign w_sd_req  = RR_MAX'(w_sd_elig);
    assign w_wk_pick = rr_find_first(w_wk_req, int'(r_rr_ptr), N_DOM);
    assign w_sd_pick = rr_find_first(w_sd_req, int'(r_rr_ptr), N_DOM);
    assign w_grant   = w_wk_pick.hit ? DW'(w_wk_pick.idx) : DW'(w_sd_pick.idx);
    assign w_rr_inc  = DW'((int'(w_grant) + 1) % N_DOM);
    assign w_abort   = activity[r_cur_dom] | wake_req[r_cur_dom] | force_on[r_cur_dom];

    assign clk_en    = r_clk_en;
    assign iso_en    = r_iso_en;
    assign pwr_en    = r_pwr_en;
    assign dom_ready = r_rdy;
    assign busy      = r_busy;
    assign cur_dom   = r_cur_dom;

    // Next-state and next-output logic of the transition sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait;
        w_clk_en_nxt = r_clk_en;
        w_iso_en_nxt = r_iso_en;
        w_pwr_en_nxt = r_pwr_en;
        w_rdy_nxt    = r_rdy;
        w_dom_on_nxt = r_dom_on;
        w_busy_nxt   = r_busy;
        w_cur_nxt    = r_cur_dom;
        w_rr_nxt     = r_rr_ptr;
        w_clear      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_wk_pick.hit) begin
                    w_pwr_en_nxt[w_grant] = 1'b1;
                    w_state_nxt = ST_WK_PWR;
                    w_wait_nxt  = 4'(PWR_RAMP - 1);
                    w_busy_nxt  = 1'b1;
                    w_cur_nxt   = w_grant;
                    w_rr_nxt    = w_rr_inc;
                end else if (w_sd_pick.hit) begin
                    w_clk_en_nxt[w_grant] = 1'b0;
                    w_rdy_nxt[w_grant]    = 1'b0;
                    w_state_nxt = ST_SD_CLK;
                    w_wait_nxt  = 4'(CLK_SETTLE - 1);
                    w_busy_nxt  = 1'b1;
                    w_cur_nxt   = w_grant;
                    w_rr_nxt    = w_rr_inc;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SD_CLK: begin
                if (w_abort) begin
                    // Only the clock was gated: simply turn it back on.
                    w_clk_en_nxt[r_cur_dom] = 1'b1;
                    w_rdy_nxt[r_cur_dom]    = 1'b1;
                    w_clear[r_cur_dom]      = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_wait == 4'd0) begin
                    w_iso_en_nxt[r_cur_dom] = 1'b1;
                    w_state_nxt = ST_SD_ISO;
                    w_wait_nxt  = 4'(ISO_SETTLE - 1);
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            ST_SD_ISO: begin
                if (w_abort) begin
                    // Rail is still up, so reuse the tail of the wake sequence.
                    w_iso_en_nxt[r_cur_dom] = 1'b0;
                    w_state_nxt = ST_WK_ISO;
                    w_wait_nxt  = 4'(ISO_SETTLE - 1);
                end else if (r_wait == 4'd0) begin
                    w_pwr_en_nxt[r_cur_dom] = 1'b0;
                    w_state_nxt = ST_SD_PWR;
                    w_wait_nxt  = 4'd0;
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            ST_SD_PWR: begin
                if (r_wait == 4'd0) begin
                    w_dom_on_nxt[r_cur_dom] = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            ST_WK_PWR: begin
                if (r_wait == 4'd0) begin
                    w_iso_en_nxt[r_cur_dom] = 1'b0;
                    w_state_nxt = ST_WK_ISO;
                    w_wait_nxt  = 4'(ISO_SETTLE - 1);
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            ST_WK_ISO: begin
                if (r_wait == 4'd0) begin
                    w_clk_en_nxt[r_cur_dom] = 1'b1;
                    w_rdy_nxt[r_cur_dom]    = 1'b1;
                    w_dom_on_nxt[r_cur_dom] = 1'b1;
                    w_clear[r_cur_dom]      = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered domain controls; reset leaves every domain on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wait    <= 4'd0;
            r_clk_en  <= '1;
            r_iso_en  <= '0;
            r_pwr_en  <= '1;
            r_rdy     <= '1;
            r_dom_on  <= '1;
            r_busy    <= 1'b0;
            r_cur_dom <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_clk_en  <= w_clk_en_nxt;
            r_iso_en  <= w_iso_en_nxt;
            r_pwr_en  <= w_pwr_en_nxt;
            r_rdy     <= w_rdy_nxt;
            r_dom_on  <= w_dom_on_nxt;
            r_busy    <= w_busy_nxt;
            r_cur_dom <= w_cur_nxt;
            r_rr_ptr  <= w_rr_nxt;
        end
    end

endmodule

// File: tb/tb_io_power_sequencer.sv
// Bench for io_power_sequencer: a time-based reference model pushes the
// expected outputs every cycle, a monitor pops and compares them, and a
// few directed checks pin down the headline timings.
module tb_io_power_sequencer;

    localparam int N   = 4;
    localparam int THR = 5;
    localparam int CS  = 2;
    localparam int IS  = 2;
    localparam int PR  = 4;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic [N-1:0] activity = '0;
    logic [N-1:0] wake_req = '0;
    logic [N-1:0] force_on = '0;
    logic [N-1:0] clk_en, iso_en, pwr_en, dom_ready;
    logic         busy;
    logic [1:0]   cur_dom;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0] c, i, p, r;
        logic         b;
        logic [1:0]   d;
    } snap_t;
    snap_t sb_q[$];

    // Reference model: each domain on/off plus one active transition timeline.
    int           m_cnt [N];
    bit           m_on  [N];
    logic [N-1:0] m_clk, m_iso, m_pwr, m_rdy;
    bit           m_busy, m_wake;
    int           m_dom, m_t, m_rr;

    io_power_sequencer #(.N_DOM(N), .IDLE_THRESHOLD(THR), .CLK_SETTLE(CS),
                         .ISO_SETTLE(IS), .PWR_RAMP(PR)) dut (
        .clk(clk), .reset(reset), .activity(activity), .wake_req(wake_req),
        .force_on(force_on), .clk_en(clk_en), .iso_en(iso_en), .pwr_en(pwr_en),
        .dom_ready(dom_ready), .busy(busy), .cur_dom(cur_dom)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_cnt[d] = 0;
            m_on[d]  = 1'b1;
        end
        m_clk = '1; m_iso = '0; m_pwr = '1; m_rdy = '1;
        m_busy = 1'b0; m_wake = 1'b0; m_dom = 0; m_t = 0; m_rr = 0;
    endtask

    function automatic int pick(input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] wk, sd;
        int g, d;
        bit w, ab;
        for (int k = 0; k < N; k++) begin
            wk[k] = !m_on[k] && (wake_req[k] || force_on[k] || activity[k]);
            sd[k] = m_on[k] && m_cnt[k] == THR && !force_on[k] && !activity[k];
        end
        for (int k = 0; k < N; k++) begin
            if (m_on[k]) m_cnt[k] = activity[k] ? 0 : ((m_cnt[k] < THR) ? m_cnt[k] + 1 : THR);
        end
        if (!m_busy) begin
            g = pick(wk);
            w = 1'b1;
            if (g < 0) begin
                g = pick(sd);
                w = 1'b0;
            end
            if (g >= 0) begin
                m_busy = 1'b1; m_dom = g; m_wake = w; m_t = 0; m_rr = (g + 1) % N;
                if (w) m_pwr[g] = 1'b1;
                else begin
                    m_clk[g] = 1'b0;
                    m_rdy[g] = 1'b0;
                end
            end
        end else begin
            d  = m_dom;
            ab = activity[d] || wake_req[d] || force_on[d];
            if (!m_wake) begin
                if (m_t < CS) begin
                    if (ab) begin
                        m_clk[d] = 1'b1; m_rdy[d] = 1'b1; m_cnt[d] = 0; m_busy = 1'b0;
                    end else if (m_t == CS - 1) m_iso[d] = 1'b1;
                end else if (m_t < CS + IS) begin
                    if (ab) begin
                        m_iso[d] = 1'b0; m_wake = 1'b1; m_t = PR - 1;
                    end else if (m_t == CS + IS - 1) m_pwr[d] = 1'b0;
                end else begin
                    m_on[d] = 1'b0; m_busy = 1'b0;
                end
            end else begin
                if (m_t == PR - 1) m_iso[d] = 1'b0;
                else if (m_t == PR + IS - 1) begin
                    m_clk[d] = 1'b1; m_rdy[d] = 1'b1; m_on[d] = 1'b1; m_cnt[d] = 0; m_busy = 1'b0;
                end
            end
            m_t++;
        end
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.c = m_clk; s.i = m_iso; s.p = m_pwr; s.r = m_rdy; s.b = m_busy; s.d = 2'(m_dom);
        return s;
    endfunction

    // Expectation producer: one snapshot per clock edge, reset flushes pending ones.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            model_reset();
            sb_q.delete();
        end else begin
            model_step();
        end
        sb_q.push_back(snap());
    end

    // Monitor: compare DUT outputs against the oldest expectation on the falling edge.
    initial forever begin
        snap_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (clk_en !== e.c || iso_en !== e.i || pwr_en !== e.p || dom_ready !== e.r ||
                busy !== e.b || (e.b && cur_dom !== e.d)) begin
                errors++;
                $display("FAIL scoreboard t=%0t got clk=%b iso=%b pwr=%b rdy=%b busy=%b dom=%0d want clk=%b iso=%b pwr=%b rdy=%b busy=%b dom=%0d",
                         $time, clk_en, iso_en, pwr_en, dom_ready, busy, cur_dom,
                         e.c, e.i, e.p, e.r, e.b, e.d);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        activity = '0; wake_req = '0; force_on = '0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        bit found;

        // Idle shutdown of every domain in round-robin order.
        do_reset();
        check("reset_clk_en", clk_en, 4'b1111);
        check("reset_busy", busy, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 5)  check("sd0_clk_hold", clk_en, 4'b1111);
            if (k == 6)  check("sd0_clk_off", clk_en, 4'b1110);
            if (k == 7)  check("sd0_iso_hold", iso_en, 4'b0000);
            if (k == 8)  check("sd0_iso_on", iso_en, 4'b0001);
            if (k == 9)  check("sd0_pwr_hold", pwr_en, 4'b1111);
            if (k == 10) check("sd0_pwr_off", pwr_en, 4'b1110);
            if (k == 11) check("sd0_busy_end", busy, 1'b0);
            if (k == 12) check("sd1_grant", cur_dom, 2'd1);
        end
        check("all_off_pwr", pwr_en, 4'b0000);
        check("all_off_busy", busy, 1'b0);

        // Wake requests on domains 1 and 3.
        wake_req = 4'b1010;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = (pwr_en[1] === 1'b1);
        end
        check("wk1_seen", found, 1'b1);
        check("wk1_first", pwr_en[3], 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 3) check("wk1_iso_hold", iso_en[1], 1'b1);
            if (i == 4) check("wk1_iso_off", iso_en[1], 1'b0);
            if (i == 5) check("wk1_rdy_hold", dom_ready[1], 1'b0);
            if (i == 6) check("wk1_rdy_on", dom_ready[1], 1'b1);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = (pwr_en[3] === 1'b1);
        end
        check("wk3_seen", found, 1'b1);
        repeat (20) tick();
        wake_req = '0;

        // Abort in the clock-gated phase of domain 2.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            tick();
            found = (busy === 1'b1 && cur_dom === 2'd2 && clk_en[2] === 1'b0 && iso_en[2] === 1'b0);
        end
        check("sdclk2_seen", found, 1'b1);
        if (found) begin
            tick();
            activity[2] = 1'b1;
            tick();
            activity[2] = 1'b0;
            check("abort_clk2_clk", clk_en[2], 1'b1);
            check("abort_clk2_iso", iso_en[2], 1'b0);
            check("abort_clk2_pwr", pwr_en[2], 1'b1);
            check("abort_clk2_busy", busy, 1'b0);
        end

        // Abort in the isolated phase of domain 0.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = (busy === 1'b1 && cur_dom === 2'd0 && iso_en[0] === 1'b1);
        end
        check("sdiso0_seen", found, 1'b1);
        if (found) begin
            activity[0] = 1'b1;
            tick();
            activity[0] = 1'b0;
            check("abort_iso0_iso", iso_en[0], 1'b0);
            check("abort_iso0_pwr", pwr_en[0], 1'b1);
            tick();
            check("abort_iso0_clk_hold", clk_en[0], 1'b0);
            tick();
            check("abort_iso0_clk_on", clk_en[0], 1'b1);
            check("abort_iso0_pwr_end", pwr_en[0], 1'b1);
        end

        // force_on keeps domain 0 up while the others power down.
        do_reset();
        force_on = 4'b0001;
        repeat (40) tick();
        check("force_clk", clk_en, 4'b0001);
        check("force_pwr", pwr_en, 4'b0001);
        check("force_rdy", dom_ready, 4'b0001);

        // Wake of domain 3 beats shutdown of domain 0; reset lands mid-ramp.
        force_on = '0;
        wake_req = 4'b1000;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (busy === 1'b1 && cur_dom === 2'd3 && pwr_en[3] === 1'b1);
        end
        check("wk3_pwr_seen", found, 1'b1);
        check("wk3_beats_sd0", clk_en[0], 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_clk", clk_en, 4'b1111);
        check("mid_rst_iso", iso_en, 4'b0000);
        check("mid_rst_pwr", pwr_en, 4'b1111);
        check("mid_rst_rdy", dom_ready, 4'b1111);
        check("mid_rst_busy", busy, 1'b0);
        wake_req = '0;
        repeat (2) tick();
        reset = 1'b0;

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int d = 0; d < N; d++) activity[d] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) wake_req = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 59) == 0) force_on = N'($urandom) & N'($urandom) & N'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
